// File: rtl/vx_axi_mem_pkg.sv
// Shared types and constants for the AXI memory slave.
// Optional feature macro: VX_AXI_MEM_RANGE_CHECK_EN (see axi_mem_slave.sv).
package vx_axi_mem_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } rd_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Number of byte-offset address bits below the word index.
  function automatic int unsigned addr_lsb(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axi_mem_slave_if.sv
// AXI4 channel bundle (AW, W, B, AR, R) with master and slave views.
interface axi_mem_slave_if #(
  parameter int AXI_DATA_WIDTH = 512,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_TID_WIDTH  = 32
);

  logic                        awvalid;
  logic                        awready;
  logic [AXI_ADDR_WIDTH-1:0]   awaddr;
  logic [AXI_TID_WIDTH-1:0]    awid;
  logic [7:0]                  awlen;
  logic [2:0]                  awsize;
  logic [1:0]                  awburst;

  logic                        wvalid;
  logic                        wready;
  logic [AXI_DATA_WIDTH-1:0]   wdata;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                        wlast;

  logic                        bvalid;
  logic                        bready;
  logic [AXI_TID_WIDTH-1:0]    bid;
  logic [1:0]                  bresp;

  logic                        arvalid;
  logic                        arready;
  logic [AXI_ADDR_WIDTH-1:0]   araddr;
  logic [AXI_TID_WIDTH-1:0]    arid;
  logic [7:0]                  arlen;
  logic [2:0]                  arsize;
  logic [1:0]                  arburst;

  logic                        rvalid;
  logic                        rready;
  logic [AXI_DATA_WIDTH-1:0]   rdata;
  logic [AXI_TID_WIDTH-1:0]    rid;
  logic [1:0]                  rresp;
  logic                        rlast;

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rid, rresp, rlast,
    input  rready
  );

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    output arvalid, araddr, arid, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rid, rresp, rlast,
    output rready
  );

endinterface

// File: rtl/axi_mem_slave_dp_ram.sv
// VX_dp_ram: byte-enabled RAM, one write port, one registered read port.
// A same-cycle read and write of one word returns the old contents.
module VX_dp_ram #(
  parameter int DATAW = 512,
  parameter int ADDRW = 12
) (
  input  logic               clk,
  input  logic               write,
  input  logic [DATAW/8-1:0] wren,
  input  logic [ADDRW-1:0]   waddr,
  input  logic [DATAW-1:0]   wdata,
  input  logic               read,
  input  logic [ADDRW-1:0]   raddr,
  output logic [DATAW-1:0]   rdata
);

  logic [DATAW-1:0] mem [2**ADDRW];
  logic [DATAW-1:0] rdata_q;

  // Byte-masked write plus read-first registered read; contents are never reset.
  always_ff @(posedge clk) begin
    if (write) begin
      for (int unsigned i = 0; i < DATAW / 8; i++) begin
        if (wren[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (read) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 memory slave: independent write and read FSMs over one VX_dp_ram.
// All bursts are treated as INCR with full-width beats.
// Optional feature macro: VX_AXI_MEM_RANGE_CHECK_EN -- beats whose word index
// lies beyond the memory are suppressed and answered with SLVERR.
module axi_mem_slave #(
  parameter int AXI_DATA_WIDTH = 512,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_TID_WIDTH  = 32,
  parameter int MEM_DEPTH_LOG2 = 12
) (
  input logic            clk,
  input logic            reset,
  axi_mem_slave_if.slave bus
);
  import vx_axi_mem_pkg::*;

  localparam int unsigned ADDR_LSB = addr_lsb(AXI_DATA_WIDTH);
  localparam int unsigned IDX_W    = AXI_ADDR_WIDTH - ADDR_LSB;

  // Word indices are held unmasked; the RAM sees only the low bits, which
  // gives modulo-depth wrap while keeping the overflow bits for range checks.
  typedef logic [IDX_W-1:0] idx_t;

  // ---------------- write side state ----------------
  wr_state_e                wstate_q, wstate_d;
  logic                     awready_q, awready_d;
  logic                     wready_q, wready_d;
  logic                     bvalid_q, bvalid_d;
  logic [1:0]               bresp_q, bresp_d;
  logic [AXI_TID_WIDTH-1:0] wid_q, wid_d;
  idx_t                     widx_q, widx_d;
  logic [7:0]               wlen_q, wlen_d;
  logic [7:0]               wcnt_q, wcnt_d;
  logic                     werr_q, werr_d;

  // ---------------- read side state ----------------
  rd_state_e                rstate_q, rstate_d;
  logic                     arready_q, arready_d;
  logic                     rvalid_q, rvalid_d;
  logic                     rlast_q, rlast_d;
  logic [1:0]               rresp_q, rresp_d;
  logic [AXI_TID_WIDTH-1:0] rid_q, rid_d;
  idx_t                     ridx_q, ridx_d;
  logic [7:0]               rlen_q, rlen_d;
  logic [7:0]               rcnt_q, rcnt_d;
  logic                     roor_q, roor_d;

  logic                      w_fire;
  logic                      w_oor;
  logic                      r_oor;
  logic                      ram_we;
  logic                      ram_re;
  logic [AXI_DATA_WIDTH-1:0] ram_rdata;
  logic                      unused_bits;

`ifdef VX_AXI_MEM_RANGE_CHECK_EN
  assign w_oor = (widx_q >> MEM_DEPTH_LOG2) != '0;
  assign r_oor = (ridx_q >> MEM_DEPTH_LOG2) != '0;
  assign unused_bits = ^{bus.awsize, bus.awburst, bus.arsize, bus.arburst,
                         bus.wlast, bus.awaddr, bus.araddr};
`else
  assign w_oor = 1'b0;
  assign r_oor = 1'b0;
  assign unused_bits = ^{bus.awsize, bus.awburst, bus.arsize, bus.arburst,
                         bus.wlast, bus.awaddr, bus.araddr, widx_q, ridx_q};
`endif

  assign w_fire = bus.wvalid && wready_q;
  assign ram_we = w_fire && !w_oor;

  // Write FSM next state: accept AW, count W beats to awlen, then respond.
  always_comb begin
    wstate_d  = wstate_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    wid_d     = wid_q;
    widx_d    = widx_q;
    wlen_d    = wlen_q;
    wcnt_d    = wcnt_q;
    werr_d    = werr_q;
    case (wstate_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (bus.awvalid && awready_q) begin
          wid_d     = bus.awid;
          widx_d    = bus.awaddr[AXI_ADDR_WIDTH-1:ADDR_LSB];
          wlen_d    = bus.awlen;
          wcnt_d    = '0;
          werr_d    = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          wstate_d  = W_DATA;
        end
      end
      W_DATA: begin
        if (w_fire) begin
          werr_d = werr_q | w_oor;
          if (wcnt_q == wlen_q) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = (werr_q | w_oor) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            wstate_d = W_RESP;
          end else begin
            wcnt_d = wcnt_q + 8'd1;
            widx_d = widx_q + 1'b1;
          end
        end
      end
      W_RESP: begin
        if (bus.bready && bvalid_q) begin
          bvalid_d  = 1'b0;
          bresp_d   = AXI_RESP_OKAY;
          awready_d = 1'b1;
          wstate_d  = W_IDLE;
        end
      end
      default: begin
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
        wstate_d  = W_IDLE;
      end
    endcase
  end

  // Read FSM next state: one RAM fetch per beat, then hold the beat until taken.
  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    rid_d     = rid_q;
    ridx_d    = ridx_q;
    rlen_d    = rlen_q;
    rcnt_d    = rcnt_q;
    roor_d    = roor_q;
    ram_re    = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (bus.arvalid && arready_q) begin
          rid_d     = bus.arid;
          ridx_d    = bus.araddr[AXI_ADDR_WIDTH-1:ADDR_LSB];
          rlen_d    = bus.arlen;
          rcnt_d    = '0;
          arready_d = 1'b0;
          rstate_d  = R_FETCH;
        end
      end
      R_FETCH: begin
        ram_re   = !r_oor;
        roor_d   = r_oor;
        rvalid_d = 1'b1;
        rlast_d  = (rcnt_q == rlen_q);
        rresp_d  = r_oor ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        rstate_d = R_DATA;
      end
      R_DATA: begin
        if (rvalid_q && bus.rready) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          rresp_d  = AXI_RESP_OKAY;
          if (rlast_q) begin
            arready_d = 1'b1;
            rstate_d  = R_IDLE;
          end else begin
            rcnt_d   = rcnt_q + 8'd1;
            ridx_d   = ridx_q + 1'b1;
            rstate_d = R_FETCH;
          end
        end
      end
      default: begin
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
        rstate_d  = R_IDLE;
      end
    endcase
  end

  // State and registered outputs for both FSMs; reset abandons any burst.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= AXI_RESP_OKAY;
      wid_q     <= '0;
      widx_q    <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      werr_q    <= 1'b0;
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= AXI_RESP_OKAY;
      rid_q     <= '0;
      ridx_q    <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      roor_q    <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      wid_q     <= wid_d;
      widx_q    <= widx_d;
      wlen_q    <= wlen_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      rid_q     <= rid_d;
      ridx_q    <= ridx_d;
      rlen_q    <= rlen_d;
      rcnt_q    <= rcnt_d;
      roor_q    <= roor_d;
    end
  end

  VX_dp_ram #(
    .DATAW (AXI_DATA_WIDTH),
    .ADDRW (MEM_DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .write (ram_we),
    .wren  (bus.wstrb),
    .waddr (widx_q[MEM_DEPTH_LOG2-1:0]),
    .wdata (bus.wdata),
    .read  (ram_re),
    .raddr (ridx_q[MEM_DEPTH_LOG2-1:0]),
    .rdata (ram_rdata)
  );

  // The RAM output register is not reset and holds stale data on suppressed
  // beats, so rdata is qualified by the registered valid/range flags.
  assign bus.rdata   = (rvalid_q && !roor_q) ? ram_rdata : '0;
  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bid     = wid_q;
  assign bus.bresp   = bresp_q;
  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rid     = rid_q;
  assign bus.rresp   = rresp_q;
  assign bus.rlast   = rlast_q;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Scoreboard bench for axi_mem_slave: drivers push expected B/R responses,
// an independent monitor pops and compares on each B/R handshake.
module tb_axi_mem_slave;
  import vx_axi_mem_pkg::*;

  localparam int DW = 512;
  localparam int AW = 32;
  localparam int IW = 32;
  localparam int DL = 12;

  typedef logic [DW-1:0] data_t;
  typedef struct {
    data_t         data;
    logic [IW-1:0] id;
    logic          last;
    logic [1:0]    resp;
  } r_exp_t;
  typedef struct {
    logic [IW-1:0] id;
    logic [1:0]    resp;
  } b_exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  axi_mem_slave_if #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .AXI_TID_WIDTH(IW)) bus ();

  axi_mem_slave #(
    .AXI_DATA_WIDTH (DW),
    .AXI_ADDR_WIDTH (AW),
    .AXI_TID_WIDTH  (IW),
    .MEM_DEPTH_LOG2 (DL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  r_exp_t      exp_r[$];
  b_exp_t      exp_b[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input data_t act, input data_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic push_r(input data_t d, input logic [IW-1:0] id, input logic last,
                        input logic [1:0] resp);
    r_exp_t e;
    e.data = d; e.id = id; e.last = last; e.resp = resp;
    exp_r.push_back(e);
  endtask

  task automatic push_b(input logic [IW-1:0] id, input logic [1:0] resp);
    b_exp_t e;
    e.id = id; e.resp = resp;
    exp_b.push_back(e);
  endtask

  // All drivers start and end at posedge+#1.
  task automatic do_aw(input logic [AW-1:0] a, input logic [IW-1:0] id, input logic [7:0] len);
    int unsigned k = 0;
    bus.awaddr = a; bus.awid = id; bus.awlen = len;
    bus.awsize = 3'd6; bus.awburst = 2'b01; bus.awvalid = 1'b1;
    @(negedge clk);
    while (!bus.awready && k < 100) begin k++; @(negedge clk); end
    if (!bus.awready) tmo("aw_wait");
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
  endtask

  task automatic do_w(input data_t d, input logic [DW/8-1:0] strb, input logic last);
    int unsigned k = 0;
    bus.wdata = d; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1'b1;
    @(negedge clk);
    while (!bus.wready && k < 100) begin k++; @(negedge clk); end
    if (!bus.wready) tmo("w_wait");
    @(posedge clk); #1;
    bus.wvalid = 1'b0;
  endtask

  task automatic do_ar(input logic [AW-1:0] a, input logic [IW-1:0] id, input logic [7:0] len);
    int unsigned k = 0;
    bus.araddr = a; bus.arid = id; bus.arlen = len;
    bus.arsize = 3'd6; bus.arburst = 2'b01; bus.arvalid = 1'b1;
    @(negedge clk);
    while (!bus.arready && k < 100) begin k++; @(negedge clk); end
    if (!bus.arready) tmo("ar_wait");
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
  endtask

  // Beat k carries base+k with all strobes set.
  task automatic write_burst(input logic [AW-1:0] a, input logic [IW-1:0] id,
                             input logic [7:0] len, input data_t base);
    push_b(id, AXI_RESP_OKAY);
    do_aw(a, id, len);
    for (int k = 0; k <= int'(len); k++)
      do_w(base + data_t'(k), '1, k == int'(len));
  endtask

  task automatic read_burst(input logic [AW-1:0] a, input logic [IW-1:0] id,
                            input logic [7:0] len, input data_t base);
    for (int k = 0; k <= int'(len); k++)
      push_r(base + data_t'(k), id, k == int'(len), AXI_RESP_OKAY);
    do_ar(a, id, len);
  endtask

  task automatic drain();
    int unsigned k = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && k < 3000) begin
      @(negedge clk); k++;
    end
    if (exp_b.size() != 0 || exp_r.size() != 0) tmo("drain");
    @(posedge clk); #1;
  endtask

  // Monitor: compares each B/R handshake against the scoreboard and checks
  // that a stalled R beat holds its payload.
  initial begin : monitor
    data_t  snap_d;
    logic   snap_l;
    bit     stall_seen;
    b_exp_t eb;
    r_exp_t er;
    stall_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (bus.bvalid && bus.bready) begin
          if (exp_b.size() == 0) begin
            tmo("b_unexpected");
          end else begin
            eb = exp_b.pop_front();
            chk("bid", data_t'(bus.bid), data_t'(eb.id));
            chk("bresp", data_t'(bus.bresp), data_t'(eb.resp));
          end
        end
        if (bus.rvalid && bus.rready) begin
          if (exp_r.size() == 0) begin
            tmo("r_unexpected");
          end else begin
            er = exp_r.pop_front();
            chk("rdata", bus.rdata, er.data);
            chk("rid", data_t'(bus.rid), data_t'(er.id));
            chk("rlast", data_t'(bus.rlast), data_t'(er.last));
            chk("rresp", data_t'(bus.rresp), data_t'(er.resp));
          end
        end
        if (bus.rvalid && !bus.rready) begin
          if (stall_seen) begin
            chk("stall_rdata", bus.rdata, snap_d);
            chk("stall_rlast", data_t'(bus.rlast), data_t'(snap_l));
          end
          snap_d = bus.rdata;
          snap_l = bus.rlast;
          stall_seen = 1'b1;
        end else begin
          stall_seen = 1'b0;
        end
      end else begin
        stall_seen = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    data_t            v;
    logic [DW/8-1:0]  strb;
    int unsigned      k;

    bus.awvalid = 1'b0; bus.awaddr = '0; bus.awid = '0; bus.awlen = '0;
    bus.awsize = '0; bus.awburst = '0;
    bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
    bus.bready = 1'b1;
    bus.arvalid = 1'b0; bus.araddr = '0; bus.arid = '0; bus.arlen = '0;
    bus.arsize = '0; bus.arburst = '0;
    bus.rready = 1'b1;
    reset = 1'b1;
    #2 reset = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_ctrl", data_t'({bus.awready, bus.wready, bus.bvalid, bus.arready,
                             bus.rvalid, bus.rlast}), '0);
    chk("rst_ids", data_t'({bus.bid, bus.bresp, bus.rid, bus.rresp}), '0);
    chk("rst_rdata", bus.rdata, '0);
    reset = 1'b1;
    #1 chk("ready_before_edge", data_t'({bus.awready, bus.arready}), '0);
    @(posedge clk); #1;
    chk("ready_after_edge", data_t'({bus.awready, bus.arready}), data_t'(2'b11));

    // Single beat at 0x40, then read latency check
    write_burst(32'h40, 32'h5, 8'd0, {64{8'hA5}});
    drain();
    push_r({64{8'hA5}}, 32'h7, 1'b1, AXI_RESP_OKAY);
    do_ar(32'h40, 32'h7, 8'd0);
    @(negedge clk); chk("rvalid_t1", data_t'(bus.rvalid), '0);
    @(negedge clk); chk("rvalid_t2", data_t'(bus.rvalid), data_t'(1));
    drain();

    // Four-beat burst at 0x1000
    write_burst(32'h1000, 32'h11, 8'd3, data_t'(1));
    drain();
    read_burst(32'h1000, 32'h12, 8'd3, data_t'(1));
    drain();

    // Byte strobe: all-ones then zero with only byte 0 enabled
    push_b(32'h21, AXI_RESP_OKAY);
    do_aw(32'h2000, 32'h21, 8'd0);
    do_w('1, '1, 1'b1);
    strb = '0;
    strb[0] = 1'b1;
    push_b(32'h22, AXI_RESP_OKAY);
    do_aw(32'h2000, 32'h22, 8'd0);
    do_w('0, strb, 1'b1);
    drain();
    v = {{63{8'hFF}}, 8'h00};
    push_r(v, 32'h23, 1'b1, AXI_RESP_OKAY);
    do_ar(32'h2000, 32'h23, 8'd0);
    drain();

    // Back-pressure on beat 2 for 5 cycles
    read_burst(32'h1000, 32'h13, 8'd3, data_t'(1));
    k = 0;
    @(negedge clk);
    while (!bus.rvalid && k < 100) begin k++; @(negedge clk); end
    if (!bus.rvalid) tmo("stall_beat1");
    @(posedge clk); #1 bus.rready = 1'b0;
    k = 0;
    @(negedge clk);
    while (!bus.rvalid && k < 100) begin k++; @(negedge clk); end
    for (int i = 0; i < 5; i++) begin
      chk("stall_rvalid", data_t'(bus.rvalid), data_t'(1));
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1 bus.rready = 1'b1;
    drain();

    // Reset after beat 2 of an 8-beat write at word 0
    do_aw(32'h0, 32'h31, 8'd7);
    do_w(data_t'(32'h100), '1, 1'b0);
    do_w(data_t'(32'h101), '1, 1'b0);
    reset = 1'b0;
    #1 chk("midrst_ctrl", data_t'({bus.awready, bus.wready, bus.bvalid, bus.arready,
                                   bus.rvalid, bus.rlast}), '0);
    @(negedge clk);
    chk("midrst_hold", data_t'({bus.awready, bus.wready, bus.bvalid, bus.arready,
                                bus.rvalid}), '0);
    reset = 1'b1;
    @(posedge clk); #1;
    write_burst(32'h80, 32'h32, 8'd0, data_t'(32'h200));
    drain();
    push_r(data_t'(32'h100), 32'h33, 1'b0, AXI_RESP_OKAY);
    push_r(data_t'(32'h101), 32'h33, 1'b0, AXI_RESP_OKAY);
    push_r(data_t'(32'h200), 32'h33, 1'b1, AXI_RESP_OKAY);
    do_ar(32'h0, 32'h33, 8'd2);
    drain();

    // Word index 2^DL: wraps to word 0, or is rejected with range checking
`ifdef VX_AXI_MEM_RANGE_CHECK_EN
    push_r('0, 32'h41, 1'b1, AXI_RESP_SLVERR);
`else
    push_r(data_t'(32'h100), 32'h41, 1'b1, AXI_RESP_OKAY);
`endif
    do_ar(32'h0004_0000, 32'h41, 8'd0);
    drain();

    // Maximum burst length: 256 beats
    write_burst(32'h8000, 32'h51, 8'd255, data_t'(32'h1000));
    drain();
    read_burst(32'h8000, 32'h52, 8'd255, data_t'(32'h1000));
    drain();

    chk("sb_empty", data_t'(exp_b.size() + exp_r.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
